// File: rtl/fifo_pkg.sv
// fifo_pkg: shared Gray-code helpers and FWFT read-port state encoding
// Used by both pointer controllers. The helpers work on MAX_W-bit values;
// callers zero-extend their pointer in and truncate the result back, which is
// exact for any width up to MAX_W.
package fifo_pkg;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {EMPTY = 2'd0, LIVE = 2'd1, HELD = 2'd2} fwft_state_t;
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/rptr_ctrl_if.sv
// rptr_ctrl_if: read-side FIFO bus between consumer, RAM, synchroniser and rptr_ctrl
//   slave  (controller): r_en, g_wptr_sync, rdata_mem in; pointers, RAM control,
//                        read data and flags out
//   master (environment): the mirror image
interface rptr_ctrl_if #(
  parameter int PTR_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  r_en;
  logic [PTR_WIDTH:0]    g_wptr_sync;
  logic [DATA_WIDTH-1:0] rdata_mem;
  logic                  mem_ren;
  logic [PTR_WIDTH-1:0]  raddr;
  logic [PTR_WIDTH:0]    b_rptr;
  logic [PTR_WIDTH:0]    g_rptr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rvalid;
  logic                  empty;
  logic                  aempty;
  logic [PTR_WIDTH:0]    rcount;
  logic                  underflow;
  modport slave (
    input  r_en, g_wptr_sync, rdata_mem,
    output mem_ren, raddr, b_rptr, g_rptr, dout, rvalid, empty, aempty, rcount, underflow
  );
  modport master (
    output r_en, g_wptr_sync, rdata_mem,
    input  mem_ren, raddr, b_rptr, g_rptr, dout, rvalid, empty, aempty, rcount, underflow
  );
endinterface

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary converter (XOR prefix from the MSB)
//   gray in  [W-1:0]  Gray-coded value
//   bin  out [W-1:0]  binary equivalent
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/rptr_ctrl.sv
// rptr_ctrl: read-domain pointer/flag controller for the dual-clock FIFO
//   rclk, rrst  read clock, asynchronous active-high reset
//   bus         rptr_ctrl_if.slave: r_en/g_wptr_sync/rdata_mem in;
//               mem_ren/raddr/b_rptr/g_rptr/dout/rvalid/empty/aempty/rcount/underflow out
//   FWFT=0 standard 1-cycle read port, FWFT=1 first-word-fall-through output stage
module rptr_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AEMPTY_LVL = 1,
  parameter int FWFT       = 0
) (
  input logic        rclk,
  input logic        rrst,
  rptr_ctrl_if.slave bus
);
  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] LVL = PW'(AEMPTY_LVL);
  logic [PTR_WIDTH:0] wptr_bin, b_rptr, b_rptr_next, g_next, g_rptr, rcount;
  logic [DATA_WIDTH-1:0] dout;
  logic mem_empty, mem_ren, rvalid, empty, aempty, underflow;
  gray_to_bin #(.W(PW)) u_g2b (.gray(bus.g_wptr_sync), .bin(wptr_bin));
  assign b_rptr_next = b_rptr + PW'(mem_ren);
  assign g_next      = PW'(bin2gray(MAX_W'(b_rptr_next)));
  // Comparing the next pointer against the incoming write pointer means a read
  // that drains memory and a newly arriving write resolve in the same edge.
  always_ff @(posedge rclk or posedge rrst)
    if (rrst) begin
      b_rptr    <= '0;
      g_rptr    <= '0;
      mem_empty <= 1'b1;
      underflow <= 1'b0;
    end else begin
      b_rptr    <= b_rptr_next;
      g_rptr    <= g_next;
      mem_empty <= g_next == bus.g_wptr_sync;
      underflow <= bus.r_en && empty;
    end
  generate
    if (FWFT != 0) begin : g_fwft
      fwft_state_t state, state_next;
      logic [DATA_WIDTH-1:0] hold;
      logic [PTR_WIDTH:0] mem_count;
      assign mem_count = wptr_bin - b_rptr;
      always_ff @(posedge rclk or posedge rrst)
        if (rrst) begin
          state <= EMPTY;
          hold  <= '0;
        end else begin
          state <= state_next;
          if (state == LIVE && !bus.r_en) hold <= bus.rdata_mem;
        end
      always_comb begin
        state_next = state;
        mem_ren    = 1'b0;
        case (state)
          EMPTY: if (!mem_empty) begin
            mem_ren    = 1'b1;
            state_next = LIVE;
          end
          LIVE, HELD: if (bus.r_en) begin
            mem_ren    = !mem_empty;
            state_next = mem_empty ? EMPTY : LIVE;
          end else state_next = HELD;
          default: state_next = EMPTY;
        endcase
      end
      assign rvalid = state != EMPTY;
      assign empty  = !rvalid;
      // Memory occupancy only counts once the registered compare has seen the
      // write; this keeps rcount at 0 through reset whatever g_wptr_sync holds.
      assign rcount = mem_empty ? PW'(rvalid) : mem_count + PW'(rvalid);
      assign aempty = rcount <= LVL;
      assign dout   = rvalid ? (state == HELD ? hold : bus.rdata_mem) : '0;
    end else begin : g_std
      logic rvalid_q, aempty_q;
      logic [PTR_WIDTH:0] rcount_q, cnt_next;
      assign mem_ren  = bus.r_en && !mem_empty;
      assign cnt_next = wptr_bin - b_rptr_next;
      always_ff @(posedge rclk or posedge rrst)
        if (rrst) begin
          rvalid_q <= 1'b0;
          rcount_q <= '0;
          aempty_q <= 1'b1;
        end else begin
          rvalid_q <= mem_ren;
          rcount_q <= cnt_next;
          aempty_q <= cnt_next <= LVL;
        end
      assign rvalid = rvalid_q;
      assign empty  = mem_empty;
      assign rcount = rcount_q;
      assign aempty = aempty_q;
      assign dout   = rvalid_q ? bus.rdata_mem : '0;
    end
  endgenerate
  assign bus.mem_ren   = mem_ren;
  assign bus.raddr     = b_rptr[PTR_WIDTH-1:0];
  assign bus.b_rptr    = b_rptr;
  assign bus.g_rptr    = g_rptr;
  assign bus.dout      = dout;
  assign bus.rvalid    = rvalid;
  assign bus.empty     = empty;
  assign bus.aempty    = aempty;
  assign bus.rcount    = rcount;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_rptr_ctrl.sv
// tb_rptr_ctrl: drives a standard-mode and an FWFT-mode rptr_ctrl from one
// writer model and checks both against a word-level FIFO reference
module tb_rptr_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_en = 1'b0;
  logic [3:0] gw = '0;
  always #5 clk = ~clk;
  rptr_ctrl_if #(.PTR_WIDTH(3), .DATA_WIDTH(8)) ifa ();
  rptr_ctrl_if #(.PTR_WIDTH(3), .DATA_WIDTH(8)) ifb ();
  rptr_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AEMPTY_LVL(1), .FWFT(0)) dut_std (.rclk(clk), .rrst(rst), .bus(ifa));
  rptr_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AEMPTY_LVL(3), .FWFT(1)) dut_fwft (.rclk(clk), .rrst(rst), .bus(ifb));
  assign ifa.r_en = r_en;
  assign ifb.r_en = r_en;
  assign ifa.g_wptr_sync = gw;
  assign ifb.g_wptr_sync = gw;
  // RAM: registered read port; output is scrambled on cycles without a read so
  // any reliance on stale RAM output shows up as a data error
  logic [7:0] ram [8];
  always @(posedge clk) ifa.rdata_mem <= ifa.mem_ren ? ram[ifa.raddr] : 8'($urandom);
  always @(posedge clk) ifb.rdata_mem <= ifb.mem_ren ? ram[ifb.raddr] : 8'($urandom);
  typedef struct packed {
    logic       mem_ren;
    logic [2:0] raddr;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic [7:0] dout;
    logic       rvalid;
    logic       empty;
    logic       aempty;
    logic [3:0] rcount;
    logic       underflow;
  } obs_t;
  obs_t obs [2];
  assign obs[0] = {ifa.mem_ren, ifa.raddr, ifa.b_rptr, ifa.g_rptr, ifa.dout, ifa.rvalid,
                   ifa.empty, ifa.aempty, ifa.rcount, ifa.underflow};
  assign obs[1] = {ifb.mem_ren, ifb.raddr, ifb.b_rptr, ifb.g_rptr, ifb.dout, ifb.rvalid,
                   ifb.empty, ifb.aempty, ifb.rcount, ifb.underflow};
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  int w_cnt = 0;
  int w_last = 0;
  int rd [2] = '{0, 0};
  bit ov [2] = '{0, 0};
  bit rv [2] = '{0, 0};
  bit ufl [2] = '{0, 0};
  int tests = 0;
  int fails = 0;
  task automatic chk(input int i, input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s %s: got %0d expected %0d at %0t", i ? "fwft" : "std", name, act, want, $time);
    end
  endtask
  // Monitor: reference model in words written / words read from RAM / output
  // slot occupancy; checked away from the active edge, then advanced to the
  // state expected after the coming edge.
  always @(negedge clk) begin
    bit vis, ren, ufl_n;
    int cnt, want;
    logic [3:0] r4;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        chk(i, "rst_empty", obs[i].empty, 1);
        chk(i, "rst_aempty", obs[i].aempty, 1);
        chk(i, "rst_rvalid", obs[i].rvalid, 0);
        chk(i, "rst_b_rptr", obs[i].b_rptr, 0);
        chk(i, "rst_g_rptr", obs[i].g_rptr, 0);
        chk(i, "rst_rcount", obs[i].rcount, 0);
        chk(i, "rst_mem_ren", obs[i].mem_ren, 0);
        chk(i, "rst_underflow", obs[i].underflow, 0);
        chk(i, "rst_dout", obs[i].dout, 0);
        rd[i] = 0;
        ov[i] = 1'b0;
        rv[i] = 1'b0;
        ufl[i] = 1'b0;
      end
      w_last = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        vis = w_last > rd[i];
        r4 = 4'(rd[i]);
        chk(i, "b_rptr", obs[i].b_rptr, r4);
        chk(i, "g_rptr", obs[i].g_rptr, r4 ^ (r4 >> 1));
        chk(i, "raddr", obs[i].raddr, rd[i] % 8);
        if (i == 0) begin
          ren = r_en && vis;
          cnt = w_last - rd[0];
          chk(0, "rvalid", obs[0].rvalid, rv[0]);
          chk(0, "empty", obs[0].empty, !vis);
          if (rv[0]) begin
            want = qa.size() ? int'(qa.pop_front()) : -1;
            chk(0, "dout", obs[0].dout, want);
          end
          ufl_n = r_en && !vis;
          rv[0] = ren;
        end else begin
          ren = vis && (!ov[1] || r_en);
          cnt = int'(ov[1]) + (vis ? w_cnt - rd[1] : 0);
          chk(1, "rvalid", obs[1].rvalid, ov[1]);
          chk(1, "empty", obs[1].empty, !ov[1]);
          if (ov[1]) begin
            want = qb.size() ? int'(qb[0]) : -1;
            chk(1, "dout", obs[1].dout, want);
            if (r_en && qb.size() > 0) void'(qb.pop_front());
          end
          ufl_n = r_en && !ov[1];
          ov[1] = ren || (ov[1] && !r_en);
        end
        chk(i, "mem_ren", obs[i].mem_ren, ren);
        chk(i, "rcount", obs[i].rcount, cnt);
        chk(i, "aempty", obs[i].aempty, cnt <= (i ? 3 : 1));
        chk(i, "underflow", obs[i].underflow, ufl[i]);
        ufl[i] = ufl_n;
        rd[i] += int'(ren);
      end
      w_last = w_cnt;
    end
  end
  // Stimulus: one call per cycle; writes land in RAM and both scoreboards,
  // throttled so no unread RAM slot is ever overwritten.
  task automatic step(input bit re, input int nw);
    logic [7:0] d;
    int rmin;
    @(posedge clk);
    #1;
    r_en = re;
    rmin = rd[0] < rd[1] ? rd[0] : rd[1];
    for (int k = 0; k < nw; k++)
      if (w_cnt - rmin < 8) begin
        d = 8'($urandom);
        ram[w_cnt % 8] = d;
        qa.push_back(d);
        qb.push_back(d);
        w_cnt++;
      end
    gw = 4'(w_cnt) ^ (4'(w_cnt) >> 1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    r_en = 1'b0;
    w_cnt = 0;
    gw = '0;
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    step(0, 8);
    repeat (14) step(1, 0);
    step(1, 4);
    repeat (8) step(1, 0);
    step(0, 4);
    repeat (3) step(0, 0);
    step(1, 0);
    repeat (3) step(0, 0);
    repeat (8) step(1, 0);
    step(0, 5);
    repeat (2) step(0, 0);
    repeat (5) step(1, 0);
    repeat (300) step($urandom_range(0, 3) == 0, $urandom_range(0, 2));
    repeat (300) step($urandom_range(0, 9) != 0, $urandom_range(0, 1));
    step(0, 8);
    repeat (2) step(0, 0);
    repeat (3) step(1, 0);
    do_reset();
    repeat (4) step(1, 0);
    repeat (60) step($urandom_range(0, 1) == 1, $urandom_range(0, 2));
    repeat (12) step(1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rptr_ctrl.md
# rptr_ctrl

Read-side controller for the dual-clock FIFO: owns the binary and Gray read pointers, the registered empty/almost-empty flags, an occupancy count and an underflow pulse. Optionally runs the read port in first-word-fall-through (FWFT) mode with a zero-bubble output stage. It sits in the read clock domain between the Gray write pointer from the 2-FF synchroniser and the FIFO RAM's 1-cycle synchronous read port. It is the parametrised successor to the basic read pointer handler.

## Interface
Parameters:
- PTR_WIDTH, 3, address bits; depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
- DATA_WIDTH, 8, word width.
- AEMPTY_LVL, 1, aempty asserts when occupancy <= AEMPTY_LVL; legal range 0..2**PTR_WIDTH-1.
- FWFT, 0, 0 = standard read port, 1 = first-word-fall-through.

Ports:
- rclk  in  1  read-domain clock; every flop is on its rising edge.
- rrst  in  1  asynchronous, active-high reset.
- r_en  in  1  read request.
- g_wptr_sync  in  PTR_WIDTH+1  synchronised Gray write pointer.
- rdata_mem  in  DATA_WIDTH  RAM read data, valid the cycle after mem_ren.
- mem_ren  out  1  RAM read enable (combinational).
- raddr  out  PTR_WIDTH  RAM read address = b_rptr[PTR_WIDTH-1:0].
- b_rptr, g_rptr  out  PTR_WIDTH+1  binary and Gray read pointers (registered).
- dout  out  DATA_WIDTH  read data.
- rvalid  out  1  dout holds a valid word.
- empty, aempty  out  1  registered empty and almost-empty flags.
- rcount  out  PTR_WIDTH+1  words available to the consumer.
- underflow  out  1  one-cycle pulse on a rejected read.

## Operation
- **Write pointer:** wptr_bin = gray2bin(g_wptr_sync).
- **Pointer update:**
  - mem_ren increments b_rptr modulo 2**(PTR_WIDTH+1).
  - g_rptr <= b_rptr_next ^ (b_rptr_next >> 1).
- **mem_empty:** internal register, mem_empty <= (bin2gray(b_rptr_next) == g_wptr_sync).
- **mem_count:** wptr_bin - b_rptr, computed modulo 2**(PTR_WIDTH+1); the result never exceeds 2**PTR_WIDTH.
- **Standard mode (FWFT=0):**
  - A read is accepted when r_en && !mem_empty; mem_ren = accepted.
  - rvalid <= accepted. dout = rdata_mem, meaningful only while rvalid=1.
  - empty = mem_empty. rcount is registered as wptr_bin - b_rptr_next.
- **FWFT mode (FWFT=1), 3-state FSM:**
  - **EMPTY:** rvalid=0. If !mem_empty: mem_ren=1, go to LIVE.
  - **LIVE:** rvalid=1, dout = rdata_mem.
    - r_en and !mem_empty: mem_ren=1, stay in LIVE (back-to-back, no bubble).
    - r_en and mem_empty: go to EMPTY.
    - !r_en: hold <= rdata_mem, go to HELD.
  - **HELD:** rvalid=1, dout = hold.
    - r_en and !mem_empty: mem_ren=1, go to LIVE.
    - r_en and mem_empty: go to EMPTY.
    - !r_en: stay in HELD.
  - Outputs: empty = !rvalid; rcount = mem_count + rvalid.
- **Flags (both modes):**
  - aempty = (rcount <= AEMPTY_LVL); in standard mode it is registered alongside rcount.
  - underflow <= r_en && empty. A rejected read never moves the pointers or the state.
- **Reset (rrst=1, async, any time including mid-burst):**
  - Pointers, rcount, dout/hold and underflow go to 0.
  - rvalid=0, empty=1, aempty=1, mem_empty=1, state=EMPTY.
  - Outputs hold these values for as long as rrst is high; the first mem_ren can occur no earlier than the first edge after rrst falls.

## Timing
- **Standard mode:** read accepted at edge k -> data on dout with rvalid=1 during cycle k+1.
- **g_wptr_sync change to flags:** a change at edge k reaches empty/aempty/rcount at edge k+1.
- **FWFT first word:** g_wptr_sync goes non-empty at edge k -> mem_empty=0 after k+1 -> mem_ren during cycle k+1 -> rvalid=1 after k+2.
- **FWFT throughput:** sustained 1 word/cycle while r_en=1 and data is available.
- **Simultaneous events:** a read that empties memory while a new write pointer arrives in the same cycle is resolved by the next-pointer compare; empty never falsely deasserts.
- **Pointer wrap:** at 2**(PTR_WIDTH+1)-1 -> 0 the Gray code changes by exactly one bit.

## Structure
- **Shared package fifo_pkg:**
  - bin2gray and gray2bin functions, parametrised by width.
  - FWFT state encoding: EMPTY=2'd0, LIVE=2'd1, HELD=2'd2.
  - Also used by the write-side controller.
- **Sub-module gray_to_bin:** a combinational XOR-prefix converter, instantiated once for g_wptr_sync.
- **Generate blocks:** the FWFT FSM and the hold register sit inside `generate if (FWFT)`.

## Test plan
All scenarios use PTR_WIDTH=3.
- **Reset:** assert rrst mid-burst with rcount=5 -> same cycle: empty=1, aempty=1, rvalid=0, b_rptr=0, g_rptr=0; after release, no mem_ren until g_wptr_sync changes.
- **Standard fill/drain:** g_wptr_sync = gray(8) = 4'b1100, r_en held high -> 8 mem_ren pulses, raddr 0..7, rcount 8->0, aempty rises when rcount=1, empty=1 after the 8th read, and a 9th read produces underflow=1 for one cycle.
- **Wrap:** 20 write/read rounds -> b_rptr wraps 15->0, g_rptr goes 4'b1000->4'b0000, and empty is never wrong.
- **FWFT zero bubble:** 4 words available, r_en=1 continuously -> dout presents words 0,1,2,3 on consecutive cycles, then rvalid=0, empty=1.
- **FWFT stall:** r_en drops in LIVE for 3 cycles while rdata_mem changes -> dout stays at the held word, state is HELD, mem_ren=0; the next r_en returns the FSM to LIVE.
- **Almost-empty threshold:** AEMPTY_LVL=3 with rcount stepping 5->2 -> aempty rises on the edge where rcount reaches 3.
